// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - data-bus interface between the LSU (master) and memory (slave)
interface lsu_if #(
    parameter int XLEN = 32
);
    logic            mem_req_o;
    logic            mem_we_o;
    logic [XLEN-1:0] mem_addr_o;
    logic [XLEN-1:0] mem_wdata_o;
    logic [3:0]      mem_wstrb_o;
    logic            mem_gnt_i;
    logic            mem_rvalid_i;
    logic [XLEN-1:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );
endinterface

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: EX handshake, data-bus FSM, load extraction and writeback
// Optional misaligned-access trap enabled by defining RISCX_LSU_MISALIGN_CHK_EN.
module lsu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [6:0]      opcode_i,
    input  logic [2:0]      fun3_i,
    input  logic [XLEN-1:0] alu_ret_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [4:0]      rd_addr_i,
    lsu_if.master           mem,
    output logic            wb_valid_o,
    output logic            wb_we_o,
    output logic [4:0]      wb_rd_addr_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic            misalign_o
);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [2:0] F3_B     = 3'b000;
    localparam logic [2:0] F3_H     = 3'b001;
    localparam logic [2:0] F3_W     = 3'b010;
    localparam logic [2:0] F3_BU    = 3'b100;
    localparam logic [2:0] F3_HU    = 3'b101;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t          state_q, state_d;
    logic            is_store_q, is_store_d;
    logic [2:0]      fun3_q, fun3_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic [4:0]      rd_q, rd_d;
    logic            wb_we_q, wb_we_d;

    logic            accept;
    logic            is_mem;
    logic            mis_acc;
    logic [2:0]      fun3_norm;
    logic            in_req;
    logic            in_done;
    logic [3:0]      strb;
    logic [XLEN-1:0] lane;

    // Unsupported size codes collapse to a word access before they are stored.
    assign fun3_norm = (fun3_i inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}) ? fun3_i : F3_W;
    assign accept    = (state_q == S_IDLE) && valid_i;
    assign is_mem    = (opcode_i == OP_LOAD) || (opcode_i == OP_STORE);
    assign in_req    = (state_q == S_REQ);
    assign in_done   = (state_q == S_DONE);

    function automatic logic [XLEN-1:0] load_extract(
        input logic [2:0]      f3,
        input logic [1:0]      ofs,
        input logic [XLEN-1:0] word
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{ofs, 3'b000} +: 8];
        h = word[{ofs[1], 4'b0000} +: 16];
        case (f3)
            F3_B:    load_extract = {{(XLEN-8){b[7]}}, b};
            F3_BU:   load_extract = {{(XLEN-8){1'b0}}, b};
            F3_H:    load_extract = {{(XLEN-16){h[15]}}, h};
            F3_HU:   load_extract = {{(XLEN-16){1'b0}}, h};
            default: load_extract = word;
        endcase
    endfunction

`ifdef RISCX_LSU_MISALIGN_CHK_EN
    logic misalign_q, misalign_d;

    always_comb begin
        mis_acc = 1'b0;
        if (fun3_norm == F3_H || fun3_norm == F3_HU) begin
            mis_acc = alu_ret_i[0];
        end else if (fun3_norm == F3_W) begin
            mis_acc = |alu_ret_i[1:0];
        end
        misalign_d = accept ? (is_mem && mis_acc) : misalign_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign misalign_o = in_done && misalign_q;
`else
    assign mis_acc    = 1'b0;
    assign misalign_o = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        fun3_d     = fun3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wb_data_d  = wb_data_q;
        rd_d       = rd_q;
        wb_we_d    = wb_we_q;
        unique case (state_q)
            S_IDLE: begin
                if (valid_i) begin
                    is_store_d = (opcode_i == OP_STORE);
                    fun3_d     = fun3_norm;
                    addr_d     = alu_ret_i;
                    wdata_d    = rs2_data_i;
                    wb_data_d  = alu_ret_i;
                    rd_d       = rd_addr_i;
                    wb_we_d    = (rd_addr_i != 5'd0) && (opcode_i != OP_STORE);
                    if (!is_mem) begin
                        state_d = S_DONE;
                    end else if (mis_acc) begin
                        state_d = S_DONE;
                        wb_we_d = 1'b0;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                // Any response beat coinciding with the grant is deliberately not sampled here.
                if (mem.mem_gnt_i) begin
                    state_d = is_store_q ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem.mem_rvalid_i) begin
                    wb_data_d = load_extract(fun3_q, addr_q[1:0], mem.mem_rdata_i);
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            is_store_q <= 1'b0;
            fun3_q     <= 3'b000;
            addr_q     <= '0;
            wdata_q    <= '0;
            wb_data_q  <= '0;
            rd_q       <= 5'd0;
            wb_we_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            fun3_q     <= fun3_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wb_data_q  <= wb_data_d;
            rd_q       <= rd_d;
            wb_we_q    <= wb_we_d;
        end
    end

    // Store lanes come only from registered state, so they hold still while waiting for grant.
    always_comb begin
        strb = 4'b1111;
        lane = wdata_q;
        case (fun3_q[1:0])
            2'b00: begin
                strb = 4'b0001 << addr_q[1:0];
                lane = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                strb = addr_q[1] ? 4'b1100 : 4'b0011;
                lane = {2{wdata_q[15:0]}};
            end
            default: begin
                strb = 4'b1111;
                lane = wdata_q;
            end
        endcase
    end

    assign ready_o         = (state_q == S_IDLE);
    assign mem.mem_req_o   = in_req;
    assign mem.mem_we_o    = in_req && is_store_q;
    assign mem.mem_addr_o  = in_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
    assign mem.mem_wdata_o = in_req ? lane : '0;
    assign mem.mem_wstrb_o = in_req ? strb : 4'b0000;

    assign wb_valid_o   = in_done;
    assign wb_we_o      = in_done && wb_we_q;
    assign wb_rd_addr_o = in_done ? rd_q : 5'd0;
    assign wb_data_o    = in_done ? wb_data_q : '0;
endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - self-checking bench for lsu: vector table with writeback scoreboard plus reset corner cases
module tb_lsu;
    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] ALU = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic        ready_o;
    logic [6:0]  opcode_i;
    logic [2:0]  fun3_i;
    logic [31:0] alu_ret_i;
    logic [31:0] rs2_data_i;
    logic [4:0]  rd_addr_i;
    logic        wb_valid_o;
    logic        wb_we_o;
    logic [4:0]  wb_rd_addr_o;
    logic [31:0] wb_data_o;
    logic        misalign_o;

    always #5 clk = ~clk;

    lsu_if bus ();

    lsu dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .opcode_i     (opcode_i),
        .fun3_i       (fun3_i),
        .alu_ret_i    (alu_ret_i),
        .rs2_data_i   (rs2_data_i),
        .rd_addr_i    (rd_addr_i),
        .mem          (bus.master),
        .wb_valid_o   (wb_valid_o),
        .wb_we_o      (wb_we_o),
        .wb_rd_addr_o (wb_rd_addr_o),
        .wb_data_o    (wb_data_o),
        .misalign_o   (misalign_o)
    );

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [4:0]  rd;
        logic [31:0] rdata;
        int          gd;
        int          rdly;
        logic [31:0] exp_data;
        logic        exp_we;
        logic        exp_mis;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        we;
        logic [4:0]  rd;
        logic        mis;
        bit          chk_data;
        int          lat;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", what, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
        input logic [31:0] rs2, input logic [4:0] rd, input logic [31:0] rdata,
        input int gd, input int rdly, input logic [31:0] exp_data, input logic exp_we,
        input logic exp_mis, input logic [3:0] exp_strb, input logic [31:0] exp_wdata
    );
        vec_t v;
        v.op = op; v.f3 = f3; v.addr = addr; v.rs2 = rs2; v.rd = rd; v.rdata = rdata;
        v.gd = gd; v.rdly = rdly; v.exp_data = exp_data; v.exp_we = exp_we;
        v.exp_mis = exp_mis; v.exp_strb = exp_strb; v.exp_wdata = exp_wdata;
        return v;
    endfunction

    task automatic idle_bus();
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = 32'h0BAD_0BAD;
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rs2, input logic [4:0] rd);
        valid_i = 1'b1; opcode_i = op; fun3_i = f3; alu_ret_i = addr; rs2_data_i = rs2; rd_addr_i = rd;
    endtask

    task automatic scramble_inputs();
        valid_i    = 1'b0;
        opcode_i   = 7'($urandom());
        fun3_i     = 3'($urandom());
        alu_ret_i  = $urandom();
        rs2_data_i = $urandom();
        rd_addr_i  = 5'($urandom());
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        sb_t e, got;
        bit  is_ld, is_st, bus_op, granted, done;
        int  cyc, nreq, wait_n;
        is_ld      = (v.op == LD);
        is_st      = (v.op == ST);
        bus_op     = (is_ld || is_st) && !v.exp_mis;
        e.data     = v.exp_data;
        e.we       = v.exp_we;
        e.rd       = v.rd;
        e.mis      = v.exp_mis;
        e.chk_data = !is_st && !v.exp_mis;
        e.lat      = !bus_op ? 1 : (is_st ? v.gd + 2 : v.gd + 3 + v.rdly);
        @(negedge clk);
        check($sformatf("v%0d ready_before", idx), 32'(ready_o), 32'd1);
        drive(v.op, v.f3, v.addr, v.rs2, v.rd);
        sb_q.push_back(e);
        @(negedge clk);
        scramble_inputs();
        cyc = 1; nreq = 0; granted = 0; wait_n = 0; done = 0;
        while (!done && cyc <= 64) begin
            idle_bus();
            if (wb_valid_o) begin
                done = 1;
                if (sb_q.size() == 0) begin
                    check($sformatf("v%0d sb_nonempty", idx), 32'd0, 32'd1);
                end else begin
                    got = sb_q.pop_front();
                    check($sformatf("v%0d latency", idx), 32'(cyc), 32'(got.lat));
                    check($sformatf("v%0d wb_we", idx), 32'(wb_we_o), 32'(got.we));
                    check($sformatf("v%0d wb_rd", idx), 32'(wb_rd_addr_o), 32'(got.rd));
                    check($sformatf("v%0d misalign", idx), 32'(misalign_o), 32'(got.mis));
                    if (got.chk_data) check($sformatf("v%0d wb_data", idx), wb_data_o, got.data);
                end
                check($sformatf("v%0d req_cycles", idx), 32'(nreq), bus_op ? 32'(v.gd + 1) : 32'd0);
            end else if (bus.mem_req_o) begin
                nreq++;
                check($sformatf("v%0d addr", idx), bus.mem_addr_o, v.addr & 32'hFFFF_FFFC);
                check($sformatf("v%0d mem_we", idx), 32'(bus.mem_we_o), 32'(is_st));
                if (is_st) begin
                    check($sformatf("v%0d wstrb", idx), 32'(bus.mem_wstrb_o), 32'(v.exp_strb));
                    check($sformatf("v%0d wdata", idx), bus.mem_wdata_o, v.exp_wdata);
                end
                if (nreq > v.gd) begin
                    bus.mem_gnt_i    = 1'b1;
                    bus.mem_rvalid_i = 1'b1;
                    granted          = 1;
                end
            end else if (granted && is_ld) begin
                wait_n++;
                if (wait_n > v.rdly) begin
                    bus.mem_rvalid_i = 1'b1;
                    bus.mem_rdata_i  = v.rdata;
                end
            end
            if (!done) begin
                @(negedge clk);
                cyc++;
            end
        end
        idle_bus();
        if (!done) begin
            check($sformatf("v%0d timeout", idx), 32'd0, 32'd1);
            void'(sb_q.pop_back());
        end
        @(negedge clk);
        check($sformatf("v%0d wb_valid_one_cycle", idx), 32'(wb_valid_o), 32'd0);
        check($sformatf("v%0d ready_after", idx), 32'(ready_o), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        valid_i = 1'b0; opcode_i = '0; fun3_i = '0; alu_ret_i = '0; rs2_data_i = '0; rd_addr_i = '0;
        idle_bus();

        vecs.push_back(mk(LD,  3'b010, 32'h100, 32'h0,        5'd1, 32'hDEAD_BEEF, 0, 0, 32'hDEAD_BEEF, 1'b1, 1'b0, 4'h0, 32'h0));
        vecs.push_back(mk(LD,  3'b000, 32'h103, 32'h0,        5'd2, 32'h8000_0000, 0, 1, 32'hFFFF_FF80, 1'b1, 1'b0, 4'h0, 32'h0));
        vecs.push_back(mk(LD,  3'b100, 32'h103, 32'h0,        5'd2, 32'h8000_0000, 1, 0, 32'h0000_0080, 1'b1, 1'b0, 4'h0, 32'h0));
        vecs.push_back(mk(LD,  3'b001, 32'h102, 32'h0,        5'd3, 32'h8001_1234, 1, 2, 32'hFFFF_8001, 1'b1, 1'b0, 4'h0, 32'h0));
        vecs.push_back(mk(LD,  3'b101, 32'h102, 32'h0,        5'd3, 32'h8001_1234, 0, 0, 32'h0000_8001, 1'b1, 1'b0, 4'h0, 32'h0));
        vecs.push_back(mk(LD,  3'b000, 32'h101, 32'h0,        5'd4, 32'h1122_3344, 0, 0, 32'h0000_0033, 1'b1, 1'b0, 4'h0, 32'h0));
        vecs.push_back(mk(LD,  3'b001, 32'h100, 32'h0,        5'd4, 32'h1234_F00F, 2, 0, 32'hFFFF_F00F, 1'b1, 1'b0, 4'h0, 32'h0));
        vecs.push_back(mk(ST,  3'b001, 32'h202, 32'h1234_ABCD, 5'd7, 32'h0,        3, 0, 32'h0,         1'b0, 1'b0, 4'b1100, 32'hABCD_ABCD));
        vecs.push_back(mk(ST,  3'b000, 32'h301, 32'h0000_00A5, 5'd8, 32'h0,        0, 0, 32'h0,         1'b0, 1'b0, 4'b0010, 32'hA5A5_A5A5));
        vecs.push_back(mk(ST,  3'b010, 32'h404, 32'hCAFE_F00D, 5'd9, 32'h0,        1, 0, 32'h0,         1'b0, 1'b0, 4'b1111, 32'hCAFE_F00D));
        vecs.push_back(mk(ALU, 3'b000, 32'h55,  32'h0,        5'd5, 32'h0,        0, 0, 32'h0000_0055, 1'b1, 1'b0, 4'h0, 32'h0));
        vecs.push_back(mk(ALU, 3'b000, 32'h55,  32'h0,        5'd0, 32'h0,        0, 0, 32'h0000_0055, 1'b0, 1'b0, 4'h0, 32'h0));
        vecs.push_back(mk(LD,  3'b010, 32'h108, 32'h0,        5'd0, 32'h0102_0304, 0, 0, 32'h0102_0304, 1'b0, 1'b0, 4'h0, 32'h0));
        vecs.push_back(mk(LD,  3'b011, 32'h10C, 32'h0,        5'd9, 32'h8765_4321, 0, 1, 32'h8765_4321, 1'b1, 1'b0, 4'h0, 32'h0));
        vecs.push_back(mk(ST,  3'b111, 32'h500, 32'h1122_3344, 5'd1, 32'h0,        0, 0, 32'h0,         1'b0, 1'b0, 4'b1111, 32'h1122_3344));
`ifdef RISCX_LSU_MISALIGN_CHK_EN
        vecs.push_back(mk(LD,  3'b010, 32'h101, 32'h0,        5'd6, 32'hA5A5_0001, 0, 0, 32'h0,         1'b0, 1'b1, 4'h0, 32'h0));
`else
        vecs.push_back(mk(LD,  3'b010, 32'h101, 32'h0,        5'd6, 32'hA5A5_0001, 0, 0, 32'hA5A5_0001, 1'b1, 1'b0, 4'h0, 32'h0));
`endif

        repeat (2) @(negedge clk);
        check("rst ready", 32'(ready_o), 32'd1);
        check("rst mem_req", 32'(bus.mem_req_o), 32'd0);
        check("rst mem_we", 32'(bus.mem_we_o), 32'd0);
        check("rst wstrb", 32'(bus.mem_wstrb_o), 32'd0);
        check("rst addr", bus.mem_addr_o, 32'd0);
        check("rst wdata", bus.mem_wdata_o, 32'd0);
        check("rst wb_valid", 32'(wb_valid_o), 32'd0);
        check("rst wb_we", 32'(wb_we_o), 32'd0);
        check("rst wb_rd", 32'(wb_rd_addr_o), 32'd0);
        check("rst wb_data", wb_data_o, 32'd0);
        check("rst misalign", 32'(misalign_o), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(i, vecs[i]);
        end

        // Reset while waiting for the load response; the late response must be ignored.
        @(negedge clk);
        drive(LD, 3'b010, 32'h100, 32'h0, 5'd1);
        @(negedge clk);
        scramble_inputs();
        check("rw req", 32'(bus.mem_req_o), 32'd1);
        bus.mem_gnt_i = 1'b1;
        @(negedge clk);
        idle_bus();
        check("rw in_wait_req", 32'(bus.mem_req_o), 32'd0);
        check("rw in_wait_ready", 32'(ready_o), 32'd0);
        rst = 1'b1;
        #1;
        check("rw rst_ready", 32'(ready_o), 32'd1);
        check("rw rst_wb_valid", 32'(wb_valid_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'hFFFF_FFFF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("rw late_rvalid_wb_valid%0d", k), 32'(wb_valid_o), 32'd0);
            check($sformatf("rw late_rvalid_ready%0d", k), 32'(ready_o), 32'd1);
        end
        idle_bus();

        // Reset while a store request is pending; bus outputs must drop at once.
        @(negedge clk);
        drive(ST, 3'b010, 32'h600, 32'h5555_AAAA, 5'd1);
        @(negedge clk);
        scramble_inputs();
        check("rr req", 32'(bus.mem_req_o), 32'd1);
        check("rr we", 32'(bus.mem_we_o), 32'd1);
        rst = 1'b1;
        #1;
        check("rr rst_req", 32'(bus.mem_req_o), 32'd0);
        check("rr rst_we", 32'(bus.mem_we_o), 32'd0);
        check("rr rst_wstrb", 32'(bus.mem_wstrb_o), 32'd0);
        check("rr rst_addr", bus.mem_addr_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.mem_gnt_i = 1'b1;
        @(negedge clk);
        idle_bus();
        check("rr idle_req", 32'(bus.mem_req_o), 32'd0);
        check("rr idle_wb_valid", 32'(wb_valid_o), 32'd0);
        check("rr idle_ready", 32'(ready_o), 32'd1);

        run_vec(99, vecs[0]);
        check("sb drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, which sets the data and address width; only 32 is supported.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 The block SHALL have port valid_i  input  1  EX result is valid this cycle.
REQ-005 The block SHALL have port ready_o  output  1  the LSU accepts EX input this cycle.
REQ-006 The block SHALL have port opcode_i  input  7  opcode of the instruction: load 0000011, store 0100011, any other value is non-memory.
REQ-007 The block SHALL have port fun3_i  input  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 The block SHALL have port alu_ret_i  input  XLEN  ALU result; this is the effective address for loads and stores.
REQ-009 The block SHALL have port rs2_data_i  input  XLEN  store data.
REQ-010 The block SHALL have port rd_addr_i  input  5  destination register.
REQ-011 The block SHALL have the data-bus ports mem_req_o out 1, mem_we_o out 1, mem_addr_o out XLEN, mem_wdata_o out XLEN, mem_wstrb_o out 4, mem_gnt_i in 1, mem_rvalid_i in 1 and mem_rdata_i in XLEN.
REQ-012 The block SHALL have the writeback ports wb_valid_o out 1, wb_we_o out 1, wb_rd_addr_o out 5, wb_data_o out XLEN and misalign_o out 1.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, REQ, WAIT and DONE; ready_o SHALL be 1 only in IDLE.
REQ-014 Handshake: in IDLE, valid_i=1 SHALL capture all inputs into registers.
REQ-015 On accept, a non-memory opcode SHALL go to DONE with wb_data_o=alu_ret_i and wb_we_o=(rd_addr_i!=0).
REQ-016 On accept, a load or store SHALL go to REQ.
REQ-017 In REQ, mem_req_o SHALL be 1 and the address, write-data and strobe outputs SHALL be held stable until mem_gnt_i=1.
REQ-018 In REQ, when mem_gnt_i=1, a store SHALL go to DONE and a load SHALL go to WAIT.
REQ-019 In WAIT, the FSM SHALL wait for mem_rvalid_i=1, then latch the extracted load data and go to DONE.
REQ-020 An mem_rvalid_i pulse arriving in the same cycle as the grant SHALL be ignored; the response is only sampled in WAIT.
REQ-021 In DONE, wb_valid_o SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-022 Stores SHALL produce wb_we_o=0.
REQ-023 Latency from accept to wb_valid_o SHALL be: non-memory 1 cycle; store 1 cycle plus grant wait; load 2 cycles plus grant wait plus response wait.
REQ-024 mem_addr_o SHALL be {addr[31:2],2'b00}.
REQ-025 mem_wstrb_o SHALL be 0001<<addr[1:0] for B, 0011<<addr[1] for H, and 1111 for W.
REQ-026 mem_wdata_o SHALL replicate the store byte or half across the word.
REQ-027 For loads, the block SHALL select the byte at addr[1:0] or the half at addr[1], sign-extending for B/H and zero-extending for BU/HU.
REQ-028 mem_we_o SHALL be 1 only for stores in REQ; mem_req_o SHALL be 0 in every state except REQ.
REQ-029 A write to x0 SHALL produce wb_we_o=0.
REQ-030 An unsupported fun3 SHALL be treated as W.

Reset
REQ-031 rst=1 SHALL immediately force IDLE and drive ready_o=1 and mem_req_o, mem_we_o, mem_wstrb_o, mem_addr_o, mem_wdata_o, wb_valid_o, wb_we_o, wb_rd_addr_o, wb_data_o and misalign_o to 0.
REQ-032 Reset asserted during REQ or WAIT SHALL abandon the access; a late mem_rvalid_i after reset SHALL be ignored in IDLE.

Configuration
REQ-033 With macro RISCX_LSU_MISALIGN_CHK_EN defined, an H/HU access with addr[0]=1, or a W access with addr[1:0]!=0, SHALL skip REQ and go directly to DONE with misalign_o=1, wb_we_o=0 and no bus request.
REQ-034 With RISCX_LSU_MISALIGN_CHK_EN undefined, misalign_o SHALL be tied to 0, H uses addr[1] and W ignores addr[1:0], and the access proceeds normally.

Verification
REQ-035 Scenario: LW, addr 0x100, gnt one cycle later, rdata 0xDEADBEEF two cycles later -> wb_data_o=0xDEADBEEF, wb_valid_o high for one cycle.
REQ-036 Scenario: LB, addr 0x103, rdata 0x80000000 -> wb_data_o=0xFFFFFF80; the same access as LBU -> 0x00000080.
REQ-037 Scenario: SH, addr 0x202, rs2 0x1234ABCD, gnt held low 3 cycles -> mem_req_o high for 4 cycles, wstrb=1100, wdata=0xABCDABCD, addr stable throughout.
REQ-038 Scenario: ADD with alu_ret 0x55, rd 5 -> wb_valid_o one cycle after accept, wb_data_o=0x55, wb_we_o=1; the same with rd 0 -> wb_we_o=0.
REQ-039 Scenario: rst pulsed while in WAIT, followed by mem_rvalid_i -> stays IDLE, ready_o=1, no wb_valid_o.
REQ-040 Scenario: with RISCX_LSU_MISALIGN_CHK_EN defined, LW at addr 0x101 -> misalign_o=1, no mem_req_o; with the macro undefined -> bus request to 0x100.
